// File: rtl/mem2axi.sv
// mem2axi: bridges the core LSU req/gnt/rvalid protocol onto single-beat
// AXI4 master transactions, one outstanding access at a time.
// Optional feature macro: MEM2AXI_ERR_EN (when defined, non-OKAY bresp/rresp
// is reported on data_err_o; otherwise data_err_o is tied low).
//
// state   | meaning
// --------+-----------------------------------------
// IDLE    | no access in flight, grant possible
// WR_REQ  | AW and/or W handshake still pending
// WR_RESP | waiting for the B response
// RD_REQ  | AR handshake pending
// RD_RESP | waiting for the R beat
module mem2axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(DATA_WIDTH/8));

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      we_q;
    logic [DATA_WIDTH/8-1:0]   be_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      aw_done, w_done;
    logic                      aw_hs, w_hs, b_hs, r_hs;
    logic                      rvalid_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      unused;

    assign data_gnt_o = data_req_i & (state_q == IDLE) & ~reset_i;

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = be_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arprot  = 3'b000;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;
    assign r_hs  = m_axi_rvalid & m_axi_rready;

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode and channel valid/ready outputs, all derived from the
    // registered state so a reset drops them in the same cycle.
    always_comb begin
        state_d       = state_q;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_gnt_o) state_d = data_we_i ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                m_axi_awvalid = ~aw_done;
                m_axi_wvalid  = ~w_done;
                if ((aw_done | (~aw_done & m_axi_awready)) &&
                    (w_done  | (~w_done  & m_axi_wready)))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_d = IDLE;
            end
            RD_REQ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on grant; AXI payload is driven from these.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (data_gnt_o) begin
            addr_q  <= data_addr_i;
            we_q    <= data_we_i;
            be_q    <= data_be_i;
            wdata_q <= data_wdata_i;
        end
    end

    // Per-channel completion flags so AW and W may finish in either order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (data_gnt_o) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Core response: one-cycle rvalid pulse, read data held until next read.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= b_hs | r_hs;
            if (r_hs) rdata_q <= m_axi_rdata;
        end
    end

`ifdef MEM2AXI_ERR_EN
    logic err_q;

    // Error flag registered alongside the response pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) err_q <= 1'b0;
        else         err_q <= (b_hs && (m_axi_bresp != 2'b00)) ||
                              (r_hs && (m_axi_rresp != 2'b00));
    end

    assign data_err_o = err_q;
    assign unused     = ^{we_q, m_axi_bid, m_axi_rid, m_axi_rlast};
`else
    assign data_err_o = 1'b0;
    assign unused     = ^{we_q, m_axi_bid, m_axi_rid, m_axi_rlast,
                          m_axi_bresp, m_axi_rresp};
`endif

endmodule
